// File: rtl/csa_frame_packer.sv
// Packs one 188-byte TS packet and its descriptor into a 55-word, 33-bit CSA scrambler frame.
// Define CSA_PACKER_STAT_EN to build the drop_cnt / err_cnt statistics counters.
module csa_frame_packer #(
    parameter int         TS_LEN    = 188,
    parameter logic [7:0] SYNC_BYTE = 8'h47
) (
    input  logic        clk_main,
    input  logic        rst,
    input  logic [7:0]  ts_in,
    input  logic        ts_in_en,
    input  logic        ts_in_sop,
    input  logic [12:0] desc_pid,
    input  logic [63:0] desc_cw,
    input  logic        desc_pid_flag,
    input  logic        desc_csa_flag,
    input  logic        desc_csa_oe,
    input  logic [7:0]  desc_gbe,
    input  logic [31:0] desc_ip,
    input  logic [15:0] desc_port,
    input  logic        fifo_pfull,
    output logic [32:0] ts_dout,
    output logic        ts_dout_en,
    output logic [31:0] frame_cnt,
    output logic [15:0] drop_cnt,
    output logic [15:0] err_cnt
);
    // Input side has no ready: every cycle with ts_in_en high transfers a byte. Once all
    // payload bytes are in, further bytes and SOPs are ignored, so a following SOP must be
    // held by the source until the frame finishes. Output side writes whenever ts_dout_en is high.
    localparam logic [7:0] LEN8      = 8'(TS_LEN);
    localparam logic [5:0] LAST_WORD = 6'(TS_LEN / 4 - 1);

    typedef enum logic [2:0] {IDLE, HDR, BODY, DROP, STUFF} state_t;
    state_t state;

    logic [7:0]  byte_cnt;
    logic [5:0]  word_cnt;
    logic        hdr_busy;
    logic [2:0]  hdr_idx;
    logic [23:0] pack_reg;
    logic [1:0]  pack_lane;
    logic [31:0] q_mem [4];
    logic [1:0]  q_wr;
    logic [1:0]  q_rd;
    logic [2:0]  q_cnt;

    logic [12:0] hdr_pid;
    logic [63:0] hdr_cw;
    logic        hdr_pid_flag;
    logic        hdr_csa_flag;
    logic        hdr_csa_oe;
    logic [7:0]  hdr_gbe;
    logic [31:0] hdr_ip;
    logic [15:0] hdr_port;

    logic        sop_seen;
    logic        sop_good;
    logic        frame_full;
    logic        take;
    logic [7:0]  take_byte;
    logic        push;
    logic        pop;
    logic        last_pop;
    logic [31:0] hdr_word;

    assign sop_seen   = ts_in_en & ts_in_sop;
    assign sop_good   = sop_seen && (ts_in == SYNC_BYTE) && !fifo_pfull;
    assign frame_full = (byte_cnt == LEN8);

    // take: a byte enters the word packer this cycle (real payload, or 8'hFF while stuffing)
    always_comb begin
        take      = 1'b0;
        take_byte = ts_in;
        case (state)
            IDLE, DROP: take = sop_good;
            HDR, BODY:  take = ts_in_en && !ts_in_sop && !frame_full;
            STUFF: begin
                take      = !frame_full;
                take_byte = 8'hFF;
            end
            default:    take = 1'b0;
        endcase
    end

    assign push     = take && (pack_lane == 2'd3);
    assign pop      = (state == BODY || state == STUFF) && !hdr_busy && (q_cnt != 3'd0);
    assign last_pop = pop && (word_cnt == LAST_WORD);

    always_comb begin
        case (hdr_idx)
            3'd1:    hdr_word = {29'd0, hdr_pid_flag, hdr_csa_flag, hdr_csa_oe};
            3'd2:    hdr_word = hdr_cw[63:32];
            3'd3:    hdr_word = hdr_cw[31:0];
            3'd4:    hdr_word = {19'd0, hdr_pid};
            3'd5:    hdr_word = {24'd0, hdr_gbe};
            3'd6:    hdr_word = hdr_ip;
            3'd7:    hdr_word = {16'd0, hdr_port};
            default: hdr_word = 32'd0;
        endcase
    end

    always_ff @(posedge clk_main) begin
        if (push) begin
            q_mem[q_wr] <= {pack_reg, take_byte};
        end
    end

    always_ff @(posedge clk_main) begin
        if (rst) begin
            state        <= IDLE;
            byte_cnt     <= 8'd0;
            word_cnt     <= 6'd0;
            hdr_busy     <= 1'b0;
            hdr_idx      <= 3'd0;
            pack_reg     <= 24'd0;
            pack_lane    <= 2'd0;
            q_wr         <= 2'd0;
            q_rd         <= 2'd0;
            q_cnt        <= 3'd0;
            hdr_pid      <= 13'd0;
            hdr_cw       <= 64'd0;
            hdr_pid_flag <= 1'b0;
            hdr_csa_flag <= 1'b0;
            hdr_csa_oe   <= 1'b0;
            hdr_gbe      <= 8'd0;
            hdr_ip       <= 32'd0;
            hdr_port     <= 16'd0;
            ts_dout      <= 33'd0;
            ts_dout_en   <= 1'b0;
            frame_cnt    <= 32'd0;
        end else begin
            ts_dout_en <= 1'b0;

            if (take) begin
                byte_cnt  <= byte_cnt + 8'd1;
                pack_reg  <= {pack_reg[15:0], take_byte};
                pack_lane <= pack_lane + 2'd1;
            end
            if (push) begin
                q_wr <= q_wr + 2'd1;
            end
            if (pop) begin
                q_rd <= q_rd + 2'd1;
            end
            q_cnt <= q_cnt + {2'b00, push} - {2'b00, pop};

            // Header words take priority; payload words only flow once w7 is out
            if (hdr_busy) begin
                ts_dout    <= {1'b0, hdr_word};
                ts_dout_en <= 1'b1;
                hdr_idx    <= hdr_idx + 3'd1;
                if (hdr_idx == 3'd7) begin
                    hdr_busy <= 1'b0;
                end
            end else if (pop) begin
                ts_dout    <= {1'b0, q_mem[q_rd]};
                ts_dout_en <= 1'b1;
                word_cnt   <= word_cnt + 6'd1;
            end

            case (state)
                IDLE, DROP: begin
                    if (sop_seen) begin
                        byte_cnt <= 8'd1;
                        if (sop_good) begin
                            state        <= HDR;
                            hdr_pid      <= desc_pid;
                            hdr_cw       <= desc_cw;
                            hdr_pid_flag <= desc_pid_flag;
                            hdr_csa_flag <= desc_csa_flag;
                            hdr_csa_oe   <= desc_csa_oe;
                            hdr_gbe      <= desc_gbe;
                            hdr_ip       <= desc_ip;
                            hdr_port     <= desc_port;
                            ts_dout      <= {1'b1, frame_cnt};
                            ts_dout_en   <= 1'b1;
                            hdr_busy     <= 1'b1;
                            hdr_idx      <= 3'd1;
                        end else begin
                            state <= DROP;
                        end
                    end else if (state == DROP && ts_in_en) begin
                        if (byte_cnt == LEN8 - 8'd1) begin
                            state    <= IDLE;
                            byte_cnt <= 8'd0;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end
                HDR: begin
                    if (sop_seen && !frame_full) begin
                        state <= STUFF;
                    end else if (hdr_idx == 3'd7) begin
                        state <= BODY;
                    end
                end
                BODY: begin
                    if (last_pop) begin
                        state     <= IDLE;
                        byte_cnt  <= 8'd0;
                        word_cnt  <= 6'd0;
                        frame_cnt <= frame_cnt + 32'd1;
                    end else if (sop_seen && !frame_full) begin
                        state <= STUFF;
                    end
                end
                STUFF: begin
                    if (last_pop) begin
                        state     <= IDLE;
                        byte_cnt  <= 8'd0;
                        word_cnt  <= 6'd0;
                        frame_cnt <= frame_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CSA_PACKER_STAT_EN
    logic drop_evt;
    logic err_evt;

    assign drop_evt = (state == IDLE || state == DROP) && sop_seen && !sop_good;
    assign err_evt  = (state == HDR || state == BODY) && sop_seen && !frame_full;

    always_ff @(posedge clk_main) begin
        if (rst) begin
            drop_cnt <= 16'd0;
            err_cnt  <= 16'd0;
        end else begin
            if (drop_evt && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (err_evt && err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`else
    assign drop_cnt = 16'd0;
    assign err_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_csa_frame_packer.sv
// Randomized bench for csa_frame_packer: a frame-level model fills an expected-word queue
// that a monitor drains against every downstream FIFO write.
module tb_csa_frame_packer;
    localparam int TS_LEN = 188;

    logic        clk_main = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ts_in = 8'd0;
    logic        ts_in_en = 1'b0;
    logic        ts_in_sop = 1'b0;
    logic [12:0] desc_pid = 13'd0;
    logic [63:0] desc_cw = 64'd0;
    logic        desc_pid_flag = 1'b0;
    logic        desc_csa_flag = 1'b0;
    logic        desc_csa_oe = 1'b0;
    logic [7:0]  desc_gbe = 8'd0;
    logic [31:0] desc_ip = 32'd0;
    logic [15:0] desc_port = 16'd0;
    logic        fifo_pfull = 1'b0;
    logic [32:0] ts_dout;
    logic        ts_dout_en;
    logic [31:0] frame_cnt;
    logic [15:0] drop_cnt;
    logic [15:0] err_cnt;

    csa_frame_packer dut (
        .clk_main      (clk_main),
        .rst           (rst),
        .ts_in         (ts_in),
        .ts_in_en      (ts_in_en),
        .ts_in_sop     (ts_in_sop),
        .desc_pid      (desc_pid),
        .desc_cw       (desc_cw),
        .desc_pid_flag (desc_pid_flag),
        .desc_csa_flag (desc_csa_flag),
        .desc_csa_oe   (desc_csa_oe),
        .desc_gbe      (desc_gbe),
        .desc_ip       (desc_ip),
        .desc_port     (desc_port),
        .fifo_pfull    (fifo_pfull),
        .ts_dout       (ts_dout),
        .ts_dout_en    (ts_dout_en),
        .frame_cnt     (frame_cnt),
        .drop_cnt      (drop_cnt),
        .err_cnt       (err_cnt)
    );

    // clock / reset
    always #5 clk_main = ~clk_main;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_writes = 0;
    bit          mon_on = 1'b1;
    logic [32:0] exp_q[$];
    logic [32:0] obs_log[$];
    logic [31:0] exp_frames = 32'd0;
    logic [15:0] exp_drop = 16'd0;
    logic [15:0] exp_err = 16'd0;
    logic [7:0]  pkt [TS_LEN];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // scoreboard: every write is compared against the head of the expected queue
    always @(negedge clk_main) begin
        if (ts_dout_en === 1'b1) begin
            n_writes++;
            obs_log.push_back(ts_dout);
            if (mon_on) begin
                if (exp_q.size() == 0) check("spurious_write", 64'(ts_dout_en), 64'd0);
                else check("frame_word", 64'(ts_dout), 64'(exp_q.pop_front()));
            end
        end
    end

    // reference model: whole frame from descriptor and payload, bytes from stuff_at on are 0xFF
    task automatic model_frame(input int stuff_at);
        logic [7:0] b [TS_LEN];
        for (int i = 0; i < TS_LEN; i++) b[i] = (i < stuff_at) ? pkt[i] : 8'hFF;
        exp_q.push_back({1'b1, exp_frames});
        exp_q.push_back({1'b0, 29'd0, desc_pid_flag, desc_csa_flag, desc_csa_oe});
        exp_q.push_back({1'b0, desc_cw[63:32]});
        exp_q.push_back({1'b0, desc_cw[31:0]});
        exp_q.push_back({1'b0, 19'd0, desc_pid});
        exp_q.push_back({1'b0, 24'd0, desc_gbe});
        exp_q.push_back({1'b0, desc_ip});
        exp_q.push_back({1'b0, 16'd0, desc_port});
        for (int w = 0; w < TS_LEN / 4; w++)
            exp_q.push_back({1'b0, b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]});
        exp_frames = exp_frames + 32'd1;
    endtask

    task automatic new_packet(input logic [7:0] first);
        desc_pid      = 13'($urandom_range(0, 8191));
        desc_cw       = {$urandom, $urandom};
        desc_pid_flag = 1'($urandom_range(0, 1));
        desc_csa_flag = 1'($urandom_range(0, 1));
        desc_csa_oe   = 1'($urandom_range(0, 1));
        desc_gbe      = 8'($urandom_range(0, 255));
        desc_ip       = $urandom;
        desc_port     = 16'($urandom_range(0, 65535));
        pkt[0] = first;
        for (int i = 1; i < TS_LEN; i++) pkt[i] = 8'($urandom_range(0, 255));
    endtask

    // driver tasks: inputs change #1 after the rising edge
    task automatic drive_byte(input logic [7:0] b, input logic sop, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                ts_in_en = 1'b0;
                @(posedge clk_main); #1;
            end
        end
        ts_in = b;
        ts_in_sop = sop;
        ts_in_en = 1'b1;
        @(posedge clk_main); #1;
        ts_in_en = 1'b0;
        ts_in_sop = 1'b0;
    endtask

    task automatic send_pkt(input int n, input bit gaps);
        for (int i = 0; i < n; i++) drive_byte(pkt[i], (i == 0), gaps && (i != 0));
    endtask

    // holds the SOP byte until the frame-start word shows it was taken
    task automatic send_pkt_held();
        bit taken = 1'b0;
        ts_in = pkt[0];
        ts_in_sop = 1'b1;
        ts_in_en = 1'b1;
        for (int k = 0; k < 400 && !taken; k++) begin
            @(posedge clk_main); #1;
            if (ts_dout_en === 1'b1 && ts_dout[32] === 1'b1) taken = 1'b1;
        end
        ts_in_en = 1'b0;
        ts_in_sop = 1'b0;
        check("held_sop_taken", 64'(taken), 64'd1);
        for (int i = 1; i < TS_LEN; i++) drive_byte(pkt[i], 1'b0, 1'b0);
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(posedge clk_main);
            k++;
        end
        repeat (4) @(posedge clk_main);
        #1;
        check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_frames));
`ifdef CSA_PACKER_STAT_EN
        check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
        check({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
`else
        check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
        check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
`endif
    endtask

    initial begin
        int base;
        bit hit;
        logic [31:0] fc0;

        rst = 1'b1;
        repeat (3) @(posedge clk_main);
        #1;
        check("reset_dout_en", 64'(ts_dout_en), 64'd0);
        check("reset_dout", 64'(ts_dout), 64'd0);
        check_stats("reset");
        rst = 1'b0;
        @(posedge clk_main); #1;

        // directed frame with known descriptor and ramp payload
        desc_pid = 13'h1FF; desc_cw = 64'h0123456789ABCDEF;
        desc_pid_flag = 1'b0; desc_csa_flag = 1'b1; desc_csa_oe = 1'b1;
        desc_gbe = 8'd2; desc_ip = 32'hC0A80001; desc_port = 16'h04D2;
        pkt[0] = 8'h47;
        for (int i = 1; i < TS_LEN; i++) pkt[i] = 8'(i);
        model_frame(TS_LEN);
        base = n_writes;
        send_pkt(TS_LEN, 1'b0);
        wait_drain("directed");
        check("directed_writes", 64'(n_writes - base), 64'd55);
        check("directed_w0", 64'(obs_log[base]), 64'h1_00000000);
        check("directed_w1", 64'(obs_log[base+1]), 64'h0_00000003);
        check("directed_w2", 64'(obs_log[base+2]), 64'h0_01234567);
        check("directed_w3", 64'(obs_log[base+3]), 64'h0_89ABCDEF);
        check("directed_w4", 64'(obs_log[base+4]), 64'h0_000001FF);
        check("directed_w7", 64'(obs_log[base+7]), 64'h0_000004D2);
        check("directed_w8", 64'(obs_log[base+8]), 64'h0_47010203);
        check_stats("directed");

        // two back-to-back packets, second SOP held until taken
        fc0 = exp_frames;
        new_packet(8'h47);
        model_frame(TS_LEN);
        base = n_writes;
        send_pkt(TS_LEN, 1'b0);
        new_packet(8'h47);
        model_frame(TS_LEN);
        send_pkt_held();
        wait_drain("b2b");
        check("b2b_writes", 64'(n_writes - base), 64'd110);
        check("b2b_second_w0", 64'(obs_log[base+55]), 64'({1'b1, fc0 + 32'd1}));
        check_stats("b2b");

        // prog_full at SOP drops the packet
        new_packet(8'h47);
        fifo_pfull = 1'b1;
        exp_drop = exp_drop + 16'd1;
        base = n_writes;
        send_pkt(TS_LEN, 1'b1);
        fifo_pfull = 1'b0;
        repeat (5) @(posedge clk_main);
        #1;
        check("pfull_writes", 64'(n_writes - base), 64'd0);
        check_stats("pfull");
        new_packet(8'h47);
        model_frame(TS_LEN);
        base = n_writes;
        send_pkt(TS_LEN, 1'b1);
        wait_drain("after_pfull");
        check("after_pfull_writes", 64'(n_writes - base), 64'd55);

        // bad sync byte
        new_packet(8'h00);
        exp_drop = exp_drop + 16'd1;
        base = n_writes;
        send_pkt(TS_LEN, 1'b0);
        repeat (5) @(posedge clk_main);
        #1;
        check("badsync_writes", 64'(n_writes - base), 64'd0);
        new_packet(8'h47);
        model_frame(TS_LEN);
        base = n_writes;
        send_pkt(TS_LEN, 1'b0);
        wait_drain("after_badsync");
        check("after_badsync_writes", 64'(n_writes - base), 64'd55);
        check_stats("badsync");

        // short bad packet cut off by a good SOP while dropping
        new_packet(8'h13);
        exp_drop = exp_drop + 16'd1;
        send_pkt(50, 1'b0);
        new_packet(8'h47);
        model_frame(TS_LEN);
        base = n_writes;
        send_pkt(TS_LEN, 1'b1);
        wait_drain("drop_resync");
        check("drop_resync_writes", 64'(n_writes - base), 64'd55);
        check_stats("drop_resync");

        // SOP at byte 100: frame stuffed with 0xFF, interrupting packet discarded
        new_packet(8'h47);
        model_frame(100);
        base = n_writes;
        send_pkt(100, 1'b1);
        new_packet(8'h47);
        exp_err = exp_err + 16'd1;
        send_pkt(TS_LEN, 1'b0);
        wait_drain("stuff");
        check("stuff_writes", 64'(n_writes - base), 64'd55);
        check("stuff_word25", 64'(obs_log[base+8+25]), 64'h0_FFFFFFFF);
        check("stuff_word46", 64'(obs_log[base+8+46]), 64'h0_FFFFFFFF);
        check_stats("stuff");

        // random packets with random gaps
        for (int r = 0; r < 6; r++) begin
            new_packet(8'h47);
            model_frame(TS_LEN);
            base = n_writes;
            send_pkt(TS_LEN, 1'b1);
            wait_drain("random");
            check("random_writes", 64'(n_writes - base), 64'd55);
        end
        check_stats("random");

        // reset in the middle of a frame, around w30
        new_packet(8'h47);
        mon_on = 1'b0;
        base = n_writes;
        hit = 1'b0;
        for (int i = 0; i < TS_LEN && !hit; i++) begin
            if (n_writes - base >= 31) hit = 1'b1;
            else drive_byte(pkt[i], (i == 0), 1'b0);
        end
        check("rst_point_reached", 64'(hit), 64'd1);
        rst = 1'b1;
        ts_in_en = 1'b0;
        @(posedge clk_main); #1;
        check("rst_dout_en", 64'(ts_dout_en), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        rst = 1'b0;
        base = n_writes;
        repeat (10) @(posedge clk_main);
        #1;
        check("rst_no_writes", 64'(n_writes - base), 64'd0);
        exp_q.delete();
        exp_frames = 32'd0;
        exp_drop = 16'd0;
        exp_err = 16'd0;
        check_stats("rst");
        mon_on = 1'b1;
        new_packet(8'h47);
        model_frame(TS_LEN);
        base = n_writes;
        send_pkt(TS_LEN, 1'b1);
        wait_drain("after_rst");
        check("after_rst_writes", 64'(n_writes - base), 64'd55);
        check("after_rst_w0", 64'(obs_log[base]), 64'h1_00000000);
        check_stats("after_rst");

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/csa_frame_packer.md
# csa_frame_packer

Builds the 55-word, 33-bit CSA scrambler frame that the CSA pretreatment stage reads from its block FIFO. Accepts one 188-byte TS packet as a byte stream plus a per-packet descriptor (PID, control word, flags, GbE port, IP/port), and writes a fixed 8-word header followed by 47 payload words into that FIFO. Sits directly upstream of the pretreatment stage; its `ts_dout`/`ts_dout_en` drive that FIFO's write side.

## Interface
- `TS_LEN`, 188: payload bytes per frame; fixed, not for reconfiguration.
- `SYNC_BYTE`, 8'h47: required first payload byte.

- `clk_main`  in  1  single clock
- `rst`  in  1  reset: synchronous, active-high
- `ts_in`  in  8  payload byte
- `ts_in_en`  in  1  byte valid; gaps allowed
- `ts_in_sop`  in  1  first byte of packet; qualified by `ts_in_en`
- `desc_pid`  in  13  PID; sampled on accepted SOP
- `desc_cw`  in  64  control word; sampled on SOP
- `desc_pid_flag`, `desc_csa_flag`, `desc_csa_oe`  in  1 each  flags; sampled on SOP
- `desc_gbe`  in  8  GbE output number; sampled on SOP
- `desc_ip`  in  32  destination IP; sampled on SOP
- `desc_port`  in  16  destination UDP port; sampled on SOP
- `fifo_pfull`  in  1  prog_full of downstream block FIFO
- `ts_dout`  out  33  frame word: bit32 = frame-start marker, bits[31:0] = data
- `ts_dout_en`  out  1  write enable to downstream FIFO
- `frame_cnt`  out  32  frames emitted
- `drop_cnt`  out  16  packets dropped (stat build only)
- `err_cnt`  out  16  truncated packets (stat build only)

## Operation
- Frame layout, words 0..54:
  - w0 `{1,frame_cnt}`
  - w1 `{0,29'b0,pid_flag,csa_flag,csa_oe}`
  - w2 `{0,cw[63:32]}`, w3 `{0,cw[31:0]}`
  - w4 `{0,16'b0,3'b0,pid}`
  - w5 `{0,24'b0,gbe}`
  - w6 `{0,ip}`, w7 `{0,16'b0,port}`
  - w8..w54 `{0,payload}`, four bytes per word, first byte in [31:24]
- States:
  - IDLE: waits for `ts_in_en & ts_in_sop`. Moves to HDR when `ts_in == SYNC_BYTE` and `fifo_pfull == 0`; otherwise moves to DROP.
  - HDR: emits w0..w7 on eight consecutive cycles, then BODY. Payload bytes arriving during HDR are packed into a 4-entry internal word queue (sized for the worst case of 8 bytes = 2 words).
  - BODY: emits a queued word whenever the queue is non-empty, one per cycle max. After 188 bytes have been accepted and w54 has been emitted, `frame_cnt` increments (wraps at 2^32) and the FSM returns to IDLE.
  - DROP: discards bytes until 188 have been counted, or a new SOP arrives; a new SOP is evaluated as in IDLE. `drop_cnt` increments once on entry.
  - STUFF: entered from HDR or BODY on an SOP before byte 188. Completes the current frame with 8'hFF bytes at one per cycle, then returns to IDLE. The interrupting packet is discarded in full. `err_cnt` increments once on entry.
- Byte counter: 8 bits; 0..187 with no wrap inside a frame.
- `fifo_pfull` is sampled only at SOP; a frame in progress is never throttled.
- Counters saturate at 16'hFFFF; `frame_cnt` wraps.

## Timing
- Reset values:
  - all outputs 0, `frame_cnt` 0, queue empty, state IDLE.
  - `rst` mid-frame aborts the frame immediately; no further words are written, and the partial frame is left to downstream resync on bit32.
- w0 appears on `ts_dout` 1 cycle after the accepted SOP byte. w7 appears 8 cycles after SOP.
- Outputs are registered. `ts_dout` holds its value when `ts_dout_en` = 0; only bits with `ts_dout_en` = 1 matter.
- With back-to-back input (188 consecutive bytes), w54 is emitted 1 cycle after the last byte's word completes in the queue. The frame occupies ≥188 cycles; the next SOP is accepted in the cycle after return to IDLE.
- An SOP in the same cycle as byte 188 of the current frame is not an error. It is evaluated on the IDLE path in the following cycle, so the source must hold that SOP byte until then.
- Exactly 55 writes per emitted frame; bit32 is set only on w0.

## Configuration
- `CSA_PACKER_STAT_EN`:
  - Defined: `drop_cnt` and `err_cnt` counters are implemented.
  - Undefined: both outputs are tied to 0 and their logic is removed. Drop and stuff behaviour are unchanged.

## Test plan
- Descriptor pid=0x1FF, cw=0x0123456789ABCDEF, flags=3'b011, gbe=2, ip=0xC0A80001, port=0x04D2, plus a 188-byte ramp starting with 0x47. Required: 55 writes; w0=0x1_00000000; w2=0x01234567; w3=0x89ABCDEF; w4=0x000001FF; w7=0x000004D2; w8=0x47010203.
- Two back-to-back packets. Required: second w0 = 0x1_00000001; 110 total writes.
- `fifo_pfull`=1 at SOP. Required: zero writes; `drop_cnt`=1 (stat build); the next packet with `fifo_pfull`=0 is packed normally.
- First byte 0x00. Required: packet dropped; a following valid packet is emitted intact.
- SOP at byte 100 of a frame. Required: that frame is stuffed to 55 words with payload bytes 100..187 = 0xFF; `err_cnt`=1; the interrupting packet produces no writes.
- `rst` asserted at w30. Required: `ts_dout_en` low from the next cycle; `frame_cnt`=0; the next packet starts at w0.
